// File: rtl/regfile_dump_controller.sv
// Streams a frozen snapshot of the register-file debug bus to a byte-wide UART TX,
// register 0 first, most significant byte of each register first.
module regfile_dump_controller #(
    parameter int PROC_BITS = 32,
    parameter int REG_COUNT = 32,
    parameter int BYTE_BITS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [REG_COUNT*PROC_BITS-1:0] i_debug_regs,
    input  logic                           i_tx_done,
    output logic                           o_tx_start,
    output logic [BYTE_BITS-1:0]           o_tx_data,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int SNAP_BITS     = REG_COUNT * PROC_BITS;
    localparam int NUM_BYTES     = SNAP_BITS / BYTE_BITS;
    localparam int BYTES_PER_REG = PROC_BITS / BYTE_BITS;
    localparam int IDX_BITS      = $clog2(NUM_BYTES);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [IDX_BITS-1:0]    idx_r, idx_nxt_s;
    logic [SNAP_BITS-1:0]   snap_r;
    logic                   capture_s;
    logic [BYTE_BITS-1:0]   data_nxt_s;
    logic                   tx_start_r, busy_r, done_r;
    logic [BYTE_BITS-1:0]   tx_data_r;

    // Byte k lives in register k/BYTES_PER_REG, lanes counted from the MSB down.
    function automatic logic [BYTE_BITS-1:0] pick_byte(
        input logic [SNAP_BITS-1:0] bus,
        input logic [IDX_BITS-1:0]  k
    );
        int reg_sel;
        int lane;
        int offset;
        reg_sel = int'(k) / BYTES_PER_REG;
        lane    = BYTES_PER_REG - 1 - (int'(k) % BYTES_PER_REG);
        offset  = reg_sel * PROC_BITS + lane * BYTE_BITS;
        return bus[offset +: BYTE_BITS];
    endfunction

    // Next-state, next-index and next-byte selection.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        capture_s   = 1'b0;
        data_nxt_s  = tx_data_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt_s = ST_SEND;
                    idx_nxt_s   = {IDX_BITS{1'b0}};
                    capture_s   = 1'b1;
                    // Snapshot is loaded on this same edge, so byte 0 comes straight off the bus.
                    data_nxt_s  = pick_byte(i_debug_regs, {IDX_BITS{1'b0}});
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SEND;
                        idx_nxt_s   = idx_r + IDX_BITS'(1);
                        data_nxt_s  = pick_byte(snap_r, idx_r + IDX_BITS'(1));
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, snapshot and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_BITS{1'b0}};
            snap_r     <= {SNAP_BITS{1'b0}};
            tx_start_r <= 1'b0;
            tx_data_r  <= {BYTE_BITS{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            if (capture_s) begin
                snap_r <= i_debug_regs;
            end
            tx_start_r <= (state_nxt_s == ST_SEND);
            tx_data_r  <= data_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_nxt_s == ST_DONE);
        end
    end

    assign o_tx_start = tx_start_r;
    assign o_tx_data  = tx_data_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;

endmodule

// File: tb/tb_regfile_dump_controller.sv
// Self-checking bench: drives dumps with random TX latency and compares the byte
// stream against a register-array model of the expected transmit order.
module tb_regfile_dump_controller;

    localparam int PROC_BITS = 32;
    localparam int REG_COUNT = 32;
    localparam int BYTE_BITS = 8;
    localparam int NBYTES    = REG_COUNT * PROC_BITS / BYTE_BITS;
    localparam int SNAP      = REG_COUNT * PROC_BITS;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_start;
    logic [SNAP-1:0] i_debug_regs;
    logic            i_tx_done;
    logic            o_tx_start;
    logic [7:0]      o_tx_data;
    logic            o_busy;
    logic            o_done;

    int err_cnt = 0;
    int chk_cnt = 0;
    int start_count = 0;
    int done_count = 0;

    logic [31:0] model_regs [REG_COUNT];

    regfile_dump_controller #(
        .PROC_BITS(PROC_BITS),
        .REG_COUNT(REG_COUNT),
        .BYTE_BITS(BYTE_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_debug_regs(i_debug_regs),
        .i_tx_done   (i_tx_done),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    // Count strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (o_tx_start) start_count <= start_count + 1;
        if (o_done)     done_count  <= done_count + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_byte(input int k);
        logic [31:0] r;
        r = model_regs[k / 4];
        return 8'((r >> (8 * (3 - (k % 4)))) & 32'h0000_00FF);
    endfunction

    function automatic logic [SNAP-1:0] pack_regs();
        logic [SNAP-1:0] v;
        v = '0;
        for (int i = 0; i < REG_COUNT; i++) v[i*32 +: 32] = model_regs[i];
        return v;
    endfunction

    // One dump from an IDLE cycle; returns in the IDLE cycle after DONE (or after abort).
    task automatic run_dump(input bit iso, input bit hold_start, input bit poke, input int abort_k);
        int base_starts;
        int extra;
        base_starts = start_count;
        i_debug_regs = pack_regs();
        i_start = 1'b1;
        i_tx_done = poke;
        tick();
        if (!hold_start) i_start = 1'b0;
        i_tx_done = 1'b0;
        if (iso) i_debug_regs = {SNAP{1'b1}};
        for (int k = 0; k < NBYTES; k++) begin
            check_val("send_start", {31'd0, o_tx_start}, 32'd1);
            check_val("send_data", {24'd0, o_tx_data}, {24'd0, model_byte(k)});
            check_val("send_busy", {31'd0, o_busy}, 32'd1);
            i_tx_done = poke && ($urandom_range(0, 3) == 0);
            tick();
            i_tx_done = 1'b0;
            extra = $urandom_range(0, 3);
            if (poke && k == 5)  extra = 100;
            if (poke && k == 10) begin
                extra = 2;
                i_start = 1'b1;
            end
            for (int j = 0; j < extra; j++) begin
                check_val("wait_start", {31'd0, o_tx_start}, 32'd0);
                check_val("wait_data", {24'd0, o_tx_data}, {24'd0, model_byte(k)});
                tick();
                if (!hold_start) i_start = 1'b0;
            end
            if (k == abort_k) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_val("abort_start", {31'd0, o_tx_start}, 32'd0);
                check_val("abort_data", {24'd0, o_tx_data}, 32'd0);
                check_val("abort_busy", {31'd0, o_busy}, 32'd0);
                check_val("abort_done", {31'd0, o_done}, 32'd0);
                repeat (20) tick();
                check_val("abort_no_more", 32'(start_count - base_starts), 32'(k + 1));
                return;
            end
            check_val("wait_idle_start", {31'd0, o_tx_start}, 32'd0);
            check_val("wait_busy", {31'd0, o_busy}, 32'd1);
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
        end
        check_val("done_pulse", {31'd0, o_done}, 32'd1);
        check_val("done_busy", {31'd0, o_busy}, 32'd1);
        check_val("done_start", {31'd0, o_tx_start}, 32'd0);
        tick();
        check_val("idle_done", {31'd0, o_done}, 32'd0);
        check_val("idle_busy", {31'd0, o_busy}, 32'd0);
        check_val("idle_start", {31'd0, o_tx_start}, 32'd0);
        check_val("byte_count", 32'(start_count - base_starts), 32'(NBYTES));
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        i_start = 1'b0;
        i_tx_done = 1'b0;
        i_debug_regs = '0;
        repeat (3) tick();
        check_val("rst_start", {31'd0, o_tx_start}, 32'd0);
        check_val("rst_data", {24'd0, o_tx_data}, 32'd0);
        check_val("rst_busy", {31'd0, o_busy}, 32'd0);
        check_val("rst_done", {31'd0, o_done}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < REG_COUNT; i++) model_regs[i] = 32'hA000_0000 + 32'(i);
        d0 = done_count;
        run_dump(1'b0, 1'b0, 1'b0, -1);
        check_val("basic_done_count", 32'(done_count - d0), 32'd1);
        run_dump(1'b1, 1'b0, 1'b0, -1);
        run_dump(1'b0, 1'b0, 1'b1, -1);

        d0 = start_count;
        i_tx_done = 1'b1;
        repeat (4) begin
            tick();
            check_val("idle_txdone_busy", {31'd0, o_busy}, 32'd0);
        end
        i_tx_done = 1'b0;
        tick();
        check_val("idle_txdone_starts", 32'(start_count - d0), 32'd0);

        run_dump(1'b0, 1'b0, 1'b0, 50);
        model_regs[0] = 32'h1234_5678;
        run_dump(1'b0, 1'b0, 1'b0, -1);

        for (int i = 0; i < REG_COUNT; i++) model_regs[i] = $urandom;
        d0 = done_count;
        run_dump(1'b0, 1'b1, 1'b1, -1);
        for (int i = 0; i < REG_COUNT; i++) model_regs[i] = $urandom;
        run_dump(1'b0, 1'b1, 1'b0, -1);
        i_start = 1'b0;
        tick();
        check_val("b2b_done_count", 32'(done_count - d0), 32'd2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
